// File: rtl/irq_controller.sv
// Prioritized, vectored interrupt controller: per-source edge latches, MASK/PENDING/STATUS
// I/O registers, and a non-nesting IDLE -> REQ -> SERVICE handshake with control.

module irq_source (
  input  logic clk,
  input  logic rst_n,
  input  logic irqIn,
  input  logic clr,
  output logic pending
);
  logic irqQ;

  // A fresh rising edge overrides any clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irqQ    <= 1'b0;
      pending <= 1'b0;
    end else begin
      irqQ    <= irqIn;
      pending <= (irqIn & ~irqQ) | (pending & ~clr);
    end
  end
endmodule

module irq_controller #(
  parameter int          NUM_IRQ     = 4,
  parameter logic [15:0] VECTOR_BASE = 16'h00F0,
  parameter logic [7:0]  BASE_ADDR   = 8'hF0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irqIn,
  input  logic               interruptEnable,
  input  logic               instrBoundary,
  output logic               irqReq,
  output logic [15:0]        irqVector,
  input  logic               irqAck,
  input  logic               irqDone,
  output logic               inService,
  input  logic [7:0]         ioAddr,
  input  logic [7:0]         ioWriteData,
  input  logic               ioWriteEn,
  input  logic               ioReadEn,
  output logic [7:0]         ioReadData
);
  localparam logic [7:0] ADDR_MASK = BASE_ADDR;
  localparam logic [7:0] ADDR_PEND = BASE_ADDR + 8'd1;
  localparam logic [7:0] ADDR_STAT = BASE_ADDR + 8'd2;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state, stateNxt;
  logic [1:0]         id, idNxt, winner;
  logic [NUM_IRQ-1:0] mask, pending, eligible, clrVec;
  logic               ackClr, wrMask, wrPend;
  logic [7:0]         statusVal, rdNxt;

  assign wrMask   = ioWriteEn && (ioAddr == ADDR_MASK);
  assign wrPend   = ioWriteEn && (ioAddr == ADDR_PEND);
  assign eligible = pending & mask;
  assign ackClr   = (state == REQ) && irqAck;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : gSrc
      assign clrVec[gi] = (wrPend & ioWriteData[gi]) | (ackClr & (id == 2'(gi)));
      irq_source uSrc (
        .clk     (clk),
        .rst_n   (rst_n),
        .irqIn   (irqIn[gi]),
        .clr     (clrVec[gi]),
        .pending (pending[gi])
      );
    end
  endgenerate

  // Scan high to low so the lowest eligible index is the one left standing.
  always_comb begin
    winner = 2'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (eligible[i]) winner = 2'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      id    <= 2'd0;
      mask  <= '0;
    end else begin
      state <= stateNxt;
      id    <= idNxt;
      if (wrMask) mask <= ioWriteData[NUM_IRQ-1:0];
    end
  end

  // Outputs decode from registered state only, so ack/done never reach irqReq combinationally.
  always_comb begin
    stateNxt  = state;
    idNxt     = id;
    irqReq    = 1'b0;
    inService = 1'b0;
    case (state)
      IDLE:
        if (instrBoundary && interruptEnable && (|eligible)) begin
          idNxt    = winner;
          stateNxt = REQ;
        end
      REQ: begin
        irqReq = 1'b1;
        if (irqAck) stateNxt = SERVICE;
      end
      SERVICE: begin
        inService = 1'b1;
        if (irqDone) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign irqVector = VECTOR_BASE + {12'd0, id, 2'b00};
  assign statusVal = {inService, irqReq, 4'd0, id};

  always_comb begin
    rdNxt = 8'd0;
    if (ioReadEn) begin
      if      (ioAddr == ADDR_MASK) rdNxt = 8'(mask);
      else if (ioAddr == ADDR_PEND) rdNxt = 8'(pending);
      else if (ioAddr == ADDR_STAT) rdNxt = statusVal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ioReadData <= 8'd0;
    else        ioReadData <= rdNxt;
  end
endmodule

// File: doc/irq_controller.md
# irq_controller

Prioritized interrupt controller for tinySoC. It latches edge-triggered requests from peripheral sources and holds per-source mask and pending registers in the I/O address space. It requests interrupt entry from `control` at instruction boundaries and supplies a per-source vector to the instruction-memory address mux. This replaces the single fixed interrupt vector with NUM_IRQ vectored sources and blocks nesting until return-from-interrupt.

## Interface
- NUM_IRQ, 4: number of sources, 1..4; index 0 is highest priority.
- VECTOR_BASE, 16'h00F0: vector of source 0; source i vectors to VECTOR_BASE + 4*i (16-bit, wraps mod 2^16).
- BASE_ADDR, 8'hF0: I/O base; MASK at +0, PENDING at +1, STATUS at +2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- irqIn  in  NUM_IRQ  source request lines, synchronous to clk, rising-edge sensitive.
- interruptEnable  in  1  global IE bit from status register.
- instrBoundary  in  1  one-cycle pulse from control: interrupt may be taken now.
- irqReq  out  1  request interrupt entry.
- irqVector  out  16  entry address for latched source.
- irqAck  in  1  control has begun entry (pulse).
- irqDone  in  1  RETI executed (pulse).
- inService  out  1  handler running.
- ioAddr  in  8  I/O address (immediate port address).
- ioWriteData  in  8  write data.
- ioWriteEn  in  1  write strobe.
- ioReadEn  in  1  read strobe.
- ioReadData  out  8  registered read data.

## Operation
- Edge detect: irqQ[i] <= irqIn[i] each clock. pending[i] is set on the clock where irqIn[i]=1 and irqQ[i]=0. Masked sources still set pending.
- Registers:
  - MASK: read/write, bit i enables source i, reset 0.
  - PENDING: read; writing 1 to bit i clears it, writing 0 has no effect.
  - STATUS: read-only; bit7 inService, bit6 irqReq, bits[1:0] latched id, others 0.
  - Bits at index >= NUM_IRQ read 0 and ignore writes.
- Reads: ioReadData <= register at ioAddr when ioReadEn and address matches, else 8'd0.
- Priority: eligible = pending & MASK; the lowest set index wins.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: when instrBoundary & interruptEnable & |eligible, latch id and go to REQ.
  - REQ: irqReq=1; id and irqVector are frozen with no preemption, even if a higher-priority source arrives. On irqAck, clear pending[id] and go to SERVICE.
  - SERVICE: irqReq=0, inService=1. On irqDone, go to IDLE. irqDone in IDLE or REQ is ignored; irqAck outside REQ is ignored.
- REQ is not withdrawn if software clears pending[id], clears MASK, or interruptEnable drops; control is committed once irqReq is seen.
- Simultaneous events:
  - Set wins over clear: a new edge plus W1C, or a new edge plus ack-clear of the same bit, leaves pending=1.
  - irqDone and a new edge in the same cycle: FSM returns to IDLE and pending is set. The next request needs another instrBoundary.
- Reset (async, any state): FSM=IDLE, MASK=0, PENDING=0, irqQ=0, id=0.
  - irqReq=0, inService=0, irqVector=VECTOR_BASE, ioReadData=0.

## Timing
- irqIn rises before edge k: pending is visible after edge k.
- instrBoundary at edge m with eligible work: irqReq=1 after edge m. Earliest from irqIn rising is 2 cycles.
- irqVector tracks latched id combinationally and is stable for the whole REQ state.
- irqAck at edge a: SERVICE and inService=1 after edge a; pending[id]=0 after edge a.
- irqDone at edge d: IDLE after edge d. A new request is possible at the next instrBoundary, at edge >= d+1.
- Register writes take effect after the write edge. Reads have one-cycle latency.
- No combinational path from irqAck or irqDone to irqReq.

## Test plan
- Single source: MASK=8'h01, pulse irqIn[0] high, instrBoundary at the next cycle with IE=1 -> irqReq=1, irqVector=16'h00F0. Then irqAck -> inService=1, PENDING reads 0. Then irqDone -> STATUS=0.
- Priority: irqIn[3] and irqIn[1] rise together, MASK=8'h0F -> vector 16'h00F4. Raise irqIn[0] during REQ -> vector unchanged. After irqDone plus boundary -> vector 16'h00F0, then 16'h00FC.
- Gating: pending with IE=0 or MASK bit 0 -> irqReq stays 0 over 10 boundaries, PENDING=1. Set IE=1 -> request on the next boundary.
- W1C race: write PENDING=8'h04 on the same cycle irqIn[2] rises -> PENDING reads 8'h04. W1C with no edge -> reads 0.
- Hold level: irqIn[0] held high for 20 cycles -> only one pending set. No re-request after irqDone until irqIn falls and rises again.
- Async reset asserted in SERVICE mid-cycle -> irqReq=0, inService=0, MASK=0, irqVector=16'h00F0 immediately, before the next clock.
